// File: rtl/bcd_convert_arbiter_pkg.sv
// Shared constants, FSM state type and digit-adjust helper for the
// round-robin binary-to-BCD converter.
package bcd_convert_arbiter_pkg;

  localparam int unsigned N_REQ        = 4;
  localparam int unsigned WIDTH        = 8;
  localparam int unsigned SHIFT_CYCLES = 8;
  localparam int unsigned CNT_W        = $clog2(SHIFT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_convert_arbiter_if.sv
// Requester/result bus between the requesters and the shared BCD converter.
interface bcd_convert_arbiter_if #(
  parameter int unsigned N_REQ = bcd_convert_arbiter_pkg::N_REQ,
  parameter int unsigned WIDTH = bcd_convert_arbiter_pkg::WIDTH
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] bin_in;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic                   done;
  logic [1:0]             hundreds;
  logic [3:0]             tens;
  logic [3:0]             ones;

  modport master (
    output req, bin_in,
    input  grant, busy, done, hundreds, tens, ones
  );

  modport slave (
    input  req, bin_in,
    output grant, busy, done, hundreds, tens, ones
  );

endinterface

// File: rtl/bcd_convert_arbiter_dd_step.sv
// One double-dabble iteration: add 3 to digits >= 5, then shift
// {hundreds,tens,ones,operand} left by one.
module dd_step
  import bcd_convert_arbiter_pkg::*;
(
  input  logic [1:0]       cur_h,
  input  logic [3:0]       cur_t,
  input  logic [3:0]       cur_o,
  input  logic [WIDTH-1:0] cur_op,
  output logic [1:0]       nxt_h,
  output logic [3:0]       nxt_t,
  output logic [3:0]       nxt_o,
  output logic [WIDTH-1:0] nxt_op
);

  logic [3:0] t_adj;
  logic [3:0] o_adj;

  // The hundreds digit never exceeds 2 for an 8-bit operand, so it needs no adjust.
  always_comb begin
    t_adj = add3(cur_t);
    o_adj = add3(cur_o);
    {nxt_h, nxt_t, nxt_o, nxt_op} = {cur_h[0], t_adj, o_adj, cur_op, 1'b0};
  end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter in front of a single sequential binary-to-BCD converter:
// capture, 8 shift cycles, one done cycle.
module bcd_convert_arbiter #(
  parameter int unsigned N_REQ = bcd_convert_arbiter_pkg::N_REQ,
  parameter int unsigned WIDTH = bcd_convert_arbiter_pkg::WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  bcd_convert_arbiter_if.slave bus
);

  import bcd_convert_arbiter_pkg::*;

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    win;
  logic             found;
  int unsigned      cand;
  logic [CNT_W-1:0] count;
  logic [1:0]       acc_h, nxt_h;
  logic [3:0]       acc_t, acc_o, nxt_t, nxt_o;
  logic [WIDTH-1:0] opnd, nxt_op;

  // Search starts just after the last served requester.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(ptr) + i) % N_REQ;
      if (!found && bus.req[PW'(cand)]) begin
        found = 1'b1;
        win   = PW'(cand);
      end
    end
  end

  dd_step u_step (
    .cur_h  (acc_h),
    .cur_t  (acc_t),
    .cur_o  (acc_o),
    .cur_op (opnd),
    .nxt_h  (nxt_h),
    .nxt_t  (nxt_t),
    .nxt_o  (nxt_o),
    .nxt_op (nxt_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= PW'(N_REQ - 1);
      owner        <= '0;
      count        <= '0;
      acc_h        <= '0;
      acc_t        <= '0;
      acc_o        <= '0;
      opnd         <= '0;
      bus.grant    <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.hundreds <= '0;
      bus.tens     <= '0;
      bus.ones     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (|bus.req) begin
            owner     <= win;
            bus.grant <= N_REQ'(1) << win;
            bus.busy  <= 1'b1;
            opnd      <= bus.bin_in[32'(win)*WIDTH +: WIDTH];
            acc_h     <= '0;
            acc_t     <= '0;
            acc_o     <= '0;
            count     <= '0;
            state     <= SHIFT;
          end else begin
            bus.grant <= '0;
            bus.busy  <= 1'b0;
          end
        end
        SHIFT: begin
          acc_h <= nxt_h;
          acc_t <= nxt_t;
          acc_o <= nxt_o;
          opnd  <= nxt_op;
          count <= count + 1'b1;
          // Final shift result goes straight to the held outputs so done can be registered.
          if (count == CNT_W'(SHIFT_CYCLES - 1)) begin
            bus.hundreds <= nxt_h;
            bus.tens     <= nxt_t;
            bus.ones     <= nxt_o;
            bus.done     <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.grant <= '0;
          bus.busy  <= 1'b0;
          ptr       <= owner;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed self-checking bench for bcd_convert_arbiter.
module tb_bcd_convert_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  bcd_convert_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  bcd_convert_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned bcd_of(input int unsigned v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int unsigned digits();
    return {22'd0, bus.hundreds, bus.tens, bus.ones};
  endfunction

  task automatic wait_done(output int unsigned lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 30);
  endtask

  // Single request from requester k; called at a negedge while the DUT is idle.
  task automatic conv(input int unsigned k, input int unsigned val);
    int unsigned lat;
    bus.bin_in[k*8 +: 8] = val[7:0];
    bus.req[k] = 1'b1;
    wait_done(lat);
    check_eq("latency", lat, 9);
    check_eq("done", bus.done, 1);
    check_eq("grant", bus.grant, 1 << k);
    check_eq("busy_at_done", bus.busy, 1);
    check_eq("digits", digits(), bcd_of(val));
    check_eq("tens_le9", (bus.tens <= 4'd9), 1);
    check_eq("ones_le9", (bus.ones <= 4'd9), 1);
    bus.req[k] = 1'b0;
    @(negedge clk);
    check_eq("done_pulse_1cyc", bus.done, 0);
    check_eq("grant_idle", bus.grant, 0);
    check_eq("busy_idle", bus.busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned lat;
    int unsigned seen;
    bus.req    = '0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_grant", bus.grant, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_digits", digits(), 0);

    conv(0, 255);
    conv(2, 0);
    conv(2, 99);

    // All four requesters held: expect strict rotation starting at 0.
    do_reset();
    bus.bin_in = {8'd40, 8'd30, 8'd20, 8'd10};
    bus.req    = 4'b1111;
    for (int unsigned i = 0; i < 5; i++) begin
      wait_done(lat);
      check_eq("rr_latency", lat, (i == 0) ? 9 : 10);
      check_eq("rr_done", bus.done, 1);
      check_eq("rr_grant", bus.grant, 1 << (i % 4));
      check_eq("rr_digits", digits(), bcd_of(10 * ((i % 4) + 1)));
    end
    bus.req = '0;
    @(negedge clk);
    check_eq("rr_done_low", bus.done, 0);
    check_eq("rr_busy_low", bus.busy, 0);

    // Reset in the middle of SHIFT aborts with no done pulse.
    bus.bin_in[7:0] = 8'd77;
    bus.req[0] = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("abort_busy_before", bus.busy, 1);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_grant", bus.grant, 0);
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_done", bus.done, 0);
    check_eq("abort_digits", digits(), 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check_eq("abort_no_done", seen, 0);
    conv(0, 42);

    // Inputs changing after capture must not disturb the conversion.
    bus.bin_in[15:8] = 8'd128;
    bus.req[1] = 1'b1;
    repeat (2) @(negedge clk);
    bus.req[1] = 1'b0;
    bus.bin_in[15:8] = 8'd5;
    wait_done(lat);
    check_eq("drop_latency", lat, 7);
    check_eq("drop_done", bus.done, 1);
    check_eq("drop_grant", bus.grant, 4'b0010);
    check_eq("drop_digits", digits(), 'h128);
    @(negedge clk);
    check_eq("drop_done_low", bus.done, 0);

    for (int unsigned v = 0; v < 256; v++) conv(3, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
